instr_fetch: RTL

- Fetch stage that sits directly upstream of the control decoder.
- Holds the PC and issues one request at a time to instruction memory.
- Captures each returned word into an IF/ID register and presents opcode/funct, the full instruction and its PC to decode.
- Applies branch/jump redirects and stalls when decode cannot accept.

---
 rtl/cpu_defs_pkg.sv | 39 +++
 rtl/instr_fetch_next_pc_calc.sv | 58 +++++
 rtl/instr_fetch.sv | 124 ++++++++++++
 3 files changed

// File: rtl/cpu_defs_pkg.sv
// Shared CPU definitions: fetch FSM encoding, redirect kinds, opcode constants
// and instruction field helpers used by fetch and the control decoder.
package cpu_defs;

  localparam int unsigned INST_W  = 32;
  localparam int unsigned OPC_W   = 6;
  localparam int unsigned FUNCT_W = 6;
  localparam int unsigned IMM_W   = 16;
  localparam int unsigned JIDX_W  = 26;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_WAIT  = 2'd2
  } fetch_state_e;

  typedef enum logic [1:0] {
    RD_NONE   = 2'd0,
    RD_BRANCH = 2'd1,
    RD_JUMP   = 2'd2
  } redir_e;

  localparam logic [OPC_W-1:0] OP_RTYPE = 6'h00;
  localparam logic [OPC_W-1:0] OP_ADDI  = 6'h08;
  localparam logic [OPC_W-1:0] OP_LW    = 6'h23;
  localparam logic [OPC_W-1:0] OP_SW    = 6'h2B;
  localparam logic [OPC_W-1:0] OP_BEQ   = 6'h04;
  localparam logic [OPC_W-1:0] OP_BNE   = 6'h05;
  localparam logic [OPC_W-1:0] OP_JMP   = 6'h02;

  function automatic logic [OPC_W-1:0] opcode_of(input logic [INST_W-1:0] inst);
    return inst[INST_W-1 -: OPC_W];
  endfunction

  function automatic logic [FUNCT_W-1:0] funct_of(input logic [INST_W-1:0] inst);
    return inst[FUNCT_W-1:0];
  endfunction

endpackage

// File: rtl/instr_fetch_next_pc_calc.sv
// Redirect target computation and jump-over-branch priority for the
// instruction held in IF/ID; purely combinational so decode tests can reuse it.
module next_pc_calc
  import cpu_defs::*;
#(
  parameter int unsigned ADDR_W = 32
) (
  input  logic              valid_i,
  input  logic [ADDR_W-1:0] if_pc_i,
  input  logic              br_taken_i,
  input  logic [IMM_W-1:0]  br_imm_i,
  input  logic              jmp_i,
  input  logic [JIDX_W-1:0] jmp_idx_i,
  output logic              redirect_c_o,
  output logic [ADDR_W-1:0] target_c_o
);

  logic [ADDR_W-1:0] pc_plus4;
  logic [ADDR_W-1:0] br_target;
  logic [ADDR_W-1:0] jmp_target;
  redir_e            kind;

  assign pc_plus4   = if_pc_i + ADDR_W'(4);
  assign br_target  = pc_plus4 + {{(ADDR_W-IMM_W-2){br_imm_i[IMM_W-1]}}, br_imm_i, 2'b00};
  assign jmp_target = ADDR_W'({pc_plus4[ADDR_W-1 -: 4], jmp_idx_i, 2'b00});

  // Jump wins when decode flags both at once.
  always_comb begin
    kind = RD_NONE;
    if (valid_i) begin
      if (jmp_i) begin
        kind = RD_JUMP;
      end else if (br_taken_i) begin
        kind = RD_BRANCH;
      end
    end
  end

  always_comb begin
    redirect_c_o = 1'b0;
    target_c_o   = pc_plus4;
    case (kind)
      RD_JUMP: begin
        redirect_c_o = 1'b1;
        target_c_o   = jmp_target;
      end
      RD_BRANCH: begin
        redirect_c_o = 1'b1;
        target_c_o   = br_target;
      end
      default: begin
        redirect_c_o = 1'b0;
        target_c_o   = pc_plus4;
      end
    endcase
  end

endmodule

// File: rtl/instr_fetch.sv
// Fetch stage: owns the PC, issues one instruction-memory request at a time,
// fills the IF/ID register and applies branch/jump redirects from decode.
module instr_fetch
  import cpu_defs::*;
#(
  parameter int unsigned       ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic               clk,
  input  logic               rst_n,
  output logic               imem_req,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic               imem_rvalid,
  input  logic [INST_W-1:0]  imem_rdata,
  output logic               if_valid,
  output logic [INST_W-1:0]  if_inst,
  output logic [ADDR_W-1:0]  if_pc,
  output logic [OPC_W-1:0]   opcode,
  output logic [FUNCT_W-1:0] funct,
  input  logic               dec_ready,
  input  logic               br_taken,
  input  logic [IMM_W-1:0]   br_imm,
  input  logic               jmp,
  input  logic [JIDX_W-1:0]  jmp_idx
);

  fetch_state_e      state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic              drop_q, drop_d;
  logic              if_valid_q, if_valid_d;
  logic [INST_W-1:0] if_inst_q, if_inst_d;
  logic [ADDR_W-1:0] if_pc_q, if_pc_d;

  logic              stall_c;
  logic              req_c;
  logic              rsp_c;
  logic              redirect_c;
  logic [ADDR_W-1:0] target_c;

  next_pc_calc #(
    .ADDR_W (ADDR_W)
  ) u_next_pc (
    .valid_i      (if_valid_q),
    .if_pc_i      (if_pc_q),
    .br_taken_i   (br_taken),
    .br_imm_i     (br_imm),
    .jmp_i        (jmp),
    .jmp_idx_i    (jmp_idx),
    .redirect_c_o (redirect_c),
    .target_c_o   (target_c)
  );

  // Only request when IF/ID is empty or being consumed this cycle.
  assign stall_c = if_valid_q && !dec_ready;
  assign req_c   = (state_q == S_FETCH) && !stall_c;
  assign rsp_c   = (state_q == S_WAIT) && imem_rvalid;

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    drop_d     = drop_q;
    if_valid_d = if_valid_q;
    if_inst_d  = if_inst_q;
    if_pc_d    = if_pc_q;

    case (state_q)
      S_IDLE:  state_d = S_FETCH;
      S_FETCH: if (req_c) state_d = S_WAIT;
      S_WAIT:  if (imem_rvalid) state_d = S_FETCH;
      default: state_d = S_IDLE;
    endcase

    if (if_valid_q && dec_ready) begin
      if_valid_d = 1'b0;
    end

    if (rsp_c) begin
      if (drop_q) begin
        drop_d = 1'b0;
      end else if (!redirect_c) begin
        if_inst_d  = imem_rdata;
        if_pc_d    = pc_q;
        if_valid_d = 1'b1;
        pc_d       = pc_q + ADDR_W'(4);
      end
    end

    // A request still in flight after this edge fetched the wrong path.
    if (redirect_c) begin
      pc_d       = target_c;
      if_valid_d = 1'b0;
      if (state_d == S_WAIT) begin
        drop_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      pc_q       <= RESET_PC;
      drop_q     <= 1'b0;
      if_valid_q <= 1'b0;
      if_inst_q  <= '0;
      if_pc_q    <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      drop_q     <= drop_d;
      if_valid_q <= if_valid_d;
      if_inst_q  <= if_inst_d;
      if_pc_q    <= if_pc_d;
    end
  end

  assign imem_req  = req_c;
  assign imem_addr = pc_q;
  assign if_valid  = if_valid_q;
  assign if_inst   = if_inst_q;
  assign if_pc     = if_pc_q;
  assign opcode    = opcode_of(if_inst_q);
  assign funct     = funct_of(if_inst_q);

endmodule
